// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the tic-tac-toe move sequencer
package ttt_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_X    = 2'b01;
    localparam logic [1:0] W_O    = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // Rows, columns, then the two diagonals; bit n of a mask is cell n.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'h054, 9'h111,
        9'h124, 9'h092, 9'h049,
        9'h1C0, 9'h038, 9'h007
    };

    localparam logic [3:0] CELL_MAX = 4'd8;

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational three-in-a-row detector for one player's board
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] board,
    output logic       win
);

    // Any of the eight lines fully covered by this board is a win.
    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_move_sequencer.sv
// rtl/ttt_move_sequencer.sv - move handshake, legality check, board registers and scoring
module ttt_move_sequencer
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_cell,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_err,
    output logic       turn,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic [8:0] board_occ,
    output logic [1:0] winner,
    output logic       game_over
);

    state_e     state_q, state_d;
    logic [8:0] board_x_q, board_x_d;
    logic [8:0] board_o_q, board_o_d;
    logic [8:0] occ_q, occ_d;
    logic       turn_q, turn_d;
    logic [1:0] winner_q, winner_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    logic [8:0] cell_bit;
    logic       cell_illegal;
    logic [8:0] mover_board;
    logic       mover_wins;

    // One-hot of the requested cell; indices above 8 shift out to zero.
    assign cell_bit     = 9'h001 << move_cell;
    assign cell_illegal = (move_cell > CELL_MAX) || ((occ_q & cell_bit) != 9'h000);

    // Only the player who just moved can have completed a line.
    assign mover_board = turn_q ? board_o_q : board_x_q;

    ttt_line_check u_line_check (
        .board (mover_board),
        .win   (mover_wins)
    );

    // Next-state: new_game clears everything, otherwise play / score / hold.
    always_comb begin
        state_d   = state_q;
        board_x_d = board_x_q;
        board_o_d = board_o_q;
        turn_d    = turn_q;
        winner_d  = winner_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        if (new_game) begin
            state_d   = PLAY;
            board_x_d = 9'h000;
            board_o_d = 9'h000;
            turn_d    = FIRST_PLAYER;
            winner_d  = W_NONE;
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_valid) begin
                        if (cell_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            if (turn_q) begin
                                board_o_d = board_o_q | cell_bit;
                            end else begin
                                board_x_d = board_x_q | cell_bit;
                            end
                            ack_d   = 1'b1;
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (mover_wins) begin
                        winner_d = turn_q ? W_O : W_X;
                        state_d  = DONE;
                    end else if (occ_q == 9'h1FF) begin
                        winner_d = W_DRAW;
                        state_d  = DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end

        occ_d = board_x_d | board_o_d;
    end

    // State and output registers; reset drops any in-flight move at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PLAY;
            board_x_q <= 9'h000;
            board_o_q <= 9'h000;
            occ_q     <= 9'h000;
            turn_q    <= FIRST_PLAYER;
            winner_q  <= W_NONE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_x_q <= board_x_d;
            board_o_q <= board_o_d;
            occ_q     <= occ_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign move_ready = (state_q == PLAY);
    assign game_over  = (state_q == DONE);
    assign move_ack   = ack_q;
    assign move_err   = err_q;
    assign turn       = turn_q;
    assign board_x    = board_x_q;
    assign board_o    = board_o_q;
    assign board_occ  = occ_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// tb/tb_ttt_move_sequencer.sv - self-checking bench for ttt_move_sequencer
module tb_ttt_move_sequencer;

    logic       clk;
    logic       rst;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_cell;

    logic       move_ready, move_ack, move_err, turn, game_over;
    logic [8:0] board_x, board_o, board_occ;
    logic [1:0] winner;

    logic       move_ready_2, move_ack_2, move_err_2, turn_2, game_over_2;
    logic [8:0] board_x_2, board_o_2, board_occ_2;
    logic [1:0] winner_2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cell owners (0 empty, 1 X, 2 O), side to move, result.
    int m_cells [9];
    int m_turn;
    int m_winner;
    bit m_done;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                         '{0,3,6}, '{1,4,7}, '{2,5,8},
                         '{0,4,8}, '{2,4,6}};

    ttt_move_sequencer #(.FIRST_PLAYER(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_cell  (move_cell),
        .move_ready (move_ready),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .turn       (turn),
        .board_x    (board_x),
        .board_o    (board_o),
        .board_occ  (board_occ),
        .winner     (winner),
        .game_over  (game_over)
    );

    ttt_move_sequencer #(.FIRST_PLAYER(1'b1)) dut_o_first (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_cell  (move_cell),
        .move_ready (move_ready_2),
        .move_ack   (move_ack_2),
        .move_err   (move_err_2),
        .turn       (turn_2),
        .board_x    (board_x_2),
        .board_o    (board_o_2),
        .board_occ  (board_occ_2),
        .winner     (winner_2),
        .game_over  (game_over_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_has_line(input int who);
        for (int l = 0; l < 8; l++) begin
            if (m_cells[lines[l][0]] == who && m_cells[lines[l][1]] == who &&
                m_cells[lines[l][2]] == who) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_full();
        for (int c = 0; c < 9; c++) if (m_cells[c] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset(input int first);
        for (int c = 0; c < 9; c++) m_cells[c] = 0;
        m_turn   = first;
        m_winner = 0;
        m_done   = 1'b0;
    endtask

    task automatic check_all(input string tag, input bit in_check);
        logic [8:0] ex, eo;
        ex = '0;
        eo = '0;
        for (int c = 0; c < 9; c++) begin
            if (m_cells[c] == 1) ex[c] = 1'b1;
            if (m_cells[c] == 2) eo[c] = 1'b1;
        end
        chk({tag, ".board_x"},   board_x,    ex);
        chk({tag, ".board_o"},   board_o,    eo);
        chk({tag, ".board_occ"}, board_occ,  ex | eo);
        chk({tag, ".turn"},      turn,       m_turn);
        chk({tag, ".winner"},    winner,     m_winner);
        chk({tag, ".game_over"}, game_over,  m_done);
        chk({tag, ".ready"},     move_ready, !m_done && !in_check);
    endtask

    // Offer one move for one cycle and follow it through scoring if accepted.
    task automatic play(input int c);
        bit legal;
        move_valid = 1'b1;
        move_cell  = c[3:0];
        @(posedge clk); #1;
        move_valid = 1'b0;
        if (m_done) begin
            chk("done.ack", move_ack, 0);
            chk("done.err", move_err, 0);
            check_all("done", 1'b0);
            return;
        end
        legal = 1'b0;
        if (c <= 8) begin
            if (m_cells[c] == 0) legal = 1'b1;
        end
        if (!legal) begin
            chk("bad.ack", move_ack, 0);
            chk("bad.err", move_err, 1);
            check_all("bad", 1'b0);
        end else begin
            m_cells[c] = m_turn + 1;
            chk("mv.ack", move_ack, 1);
            chk("mv.err", move_err, 0);
            check_all("mv", 1'b1);
            @(posedge clk); #1;
            chk("chk.ack", move_ack, 0);
            if (model_has_line(m_turn + 1)) begin
                m_winner = m_turn + 1;
                m_done   = 1'b1;
            end else if (model_full()) begin
                m_winner = 3;
                m_done   = 1'b1;
            end else begin
                m_turn = 1 - m_turn;
            end
            check_all("chk", 1'b0);
        end
    endtask

    task automatic start_game(input bit with_move);
        new_game   = 1'b1;
        move_valid = with_move;
        move_cell  = 4'd5;
        @(posedge clk); #1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_reset(0);
        chk("ng.ack", move_ack, 0);
        chk("ng.err", move_err, 0);
        check_all("ng", 1'b0);
    endtask

    initial begin
        int tries;
        rst        = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_cell  = 4'd0;
        model_reset(0);
        @(posedge clk); @(posedge clk); #1;
        check_all("rst", 1'b0);
        chk("rst.ack", move_ack, 0);
        chk("rst.err", move_err, 0);
        chk("rst2.turn", turn_2, 1);
        chk("rst2.occ", board_occ_2, 0);
        chk("rst2.ready", move_ready_2, 1);
        chk("rst2.over", game_over_2 | move_ack_2 | move_err_2, 0);
        chk("rst2.winner", winner_2, 0);
        chk("rst2.boards", {board_x_2, board_o_2}, 0);
        rst = 1'b0;

        // X takes the top row.
        play(0); play(3); play(1); play(4); play(2);
        chk("xwin.board_x", board_x, 9'h007);
        chk("xwin.board_o", board_o, 9'h018);
        chk("xwin.winner", winner, 2'b01);
        chk("xwin.over", game_over, 1);

        // Requests while finished are ignored silently.
        play(5); play(6); play(7);
        start_game(1'b1);

        // Out-of-range cell, then an occupied cell, including back-to-back retries.
        play(0);
        play(9);
        play(0);
        play(15);
        chk("ill.turn", turn, 1);
        play(4);

        // Draw.
        start_game(1'b0);
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(6); play(8);
        chk("draw.occ", board_occ, 9'h1FF);
        chk("draw.winner", winner, 2'b11);

        // O wins on the anti-diagonal.
        start_game(1'b0);
        play(0); play(2); play(1); play(4); play(8); play(6);
        chk("owin.winner", winner, 2'b10);
        chk("owin.board_o", board_o, 9'h054);

        // Random games including illegal and occupied cells.
        for (int g = 0; g < 8; g++) begin
            start_game($urandom_range(0, 1) == 1);
            tries = 0;
            while (!m_done && tries < 80) begin
                play(int'($urandom_range(0, 10)));
                tries++;
            end
            chk("rand.finished", m_done, 1);
        end

        // Asynchronous reset while scoring.
        start_game(1'b0);
        move_valid = 1'b1;
        move_cell  = 4'd4;
        @(posedge clk); #1;
        move_valid = 1'b0;
        chk("arst.pre_ack", move_ack, 1);
        chk("arst.pre_ready", move_ready, 0);
        #1 rst = 1'b1;
        #1;
        model_reset(0);
        check_all("arst", 1'b0);
        chk("arst.ack", move_ack, 0);
        chk("arst2.turn", turn_2, 1);
        chk("arst2.occ", board_occ_2, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_all("arst.after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ttt_move_sequencer.md
# ttt_move_sequencer

Player-side front end for the tic-tac-toe game logic. It accepts one move per handshake as a cell index (0–8), alternates X and O, and rejects illegal moves. It maintains registered per-player board bitmaps plus the 9-bit occupancy word that drives the game block's `in[8:0]` port. After each accepted move it scores the board and reports a win or draw, then locks until a new game is started.

## Interface
- `FIRST_PLAYER`, default 0: player who moves first after reset or `new_game` (0 = X, 1 = O).
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `new_game` input 1: synchronous clear of board and result; has priority over `move_valid`.
- `move_valid` input 1: move request.
- `move_cell` input 4: cell index. Bit *n* of the boards corresponds to cell *n*. Legal values are 0–8.
- `move_ready` output 1: high only in PLAY.
- `move_ack` output 1: one-cycle pulse when a legal move is committed.
- `move_err` output 1: one-cycle pulse when a handshaken move is rejected.
- `turn` output 1: player to move (0 = X, 1 = O).
- `board_x` output 9: cells held by X.
- `board_o` output 9: cells held by O.
- `board_occ` output 9: `board_x | board_o`, registered. Feeds the game block's `in[8:0]`.
- `winner` output 2: 00 none, 01 X, 10 O, 11 draw.
- `game_over` output 1: high in DONE.

## Operation
- **States:** PLAY, CHECK, DONE.
- **Reset values:** state PLAY; boards 0; `turn` = FIRST_PLAYER; `winner` 00; `move_ack`, `move_err`, `game_over` 0; `move_ready` 1.
- **PLAY:**
  - A handshake occurs when `move_valid && move_ready`.
  - If `move_cell` > 8 or the cell is occupied: pulse `move_err`; board, turn and state are unchanged.
  - Otherwise: set the cell's bit in the mover's board, pulse `move_ack`, go to CHECK.
- **CHECK:**
  - Evaluate the 8 win lines (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6) against the mover's board only.
  - Win: `winner` = mover, go to DONE.
  - Else, if `board_occ` = 9'h1FF: `winner` = 11 (draw), go to DONE.
  - Else: toggle `turn`, return to PLAY.
  - A full board containing a win reports the win, not a draw.
- **DONE:**
  - `move_ready` is 0, so moves are ignored; no error pulse is generated.
  - Outputs hold until `new_game` or `rst`.
- **`new_game`:** in any state, on the next edge, returns all outputs to their reset values. A simultaneous move is dropped with no ack and no err.
- **`rst` mid-CHECK:** the board and result are lost immediately; no partial update is retained.

## Timing
- A move handshaken at edge N produces the following:
  - `board_*` updated and `move_ack` high after edge N.
  - After edge N+1: `winner`/`game_over` valid, or `turn` toggled and `move_ready` high again.
- Maximum throughput is one move per 2 cycles.
- `move_err` has 1-cycle latency, and `move_ready` stays high, so back-to-back retries are legal every cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Package `ttt_pkg`:**
  - state enum {PLAY, CHECK, DONE};
  - winner encodings `W_NONE`/`W_X`/`W_O`/`W_DRAW`;
  - `WIN_LINES`: a constant array of 8 9-bit masks;
  - `CELL_MAX` = 8.
- **Sub-module `ttt_line_check`:** combinational; input a 9-bit board, output 1-bit win (OR over `(board & mask) == mask`). It is instantiated once, with its input muxed by `turn`.

## Test plan
- **Reset, then X win on the top row:** X plays cells 0, 1, 2 and O plays 3, 4. Expect `board_x` = 9'h007, `board_o` = 9'h018, `winner` = 01, `game_over` = 1 one cycle after the 5th ack.
- **Illegal moves:** `move_cell` = 9, then a replay of an occupied cell 0. Each gives a `move_err` pulse, boards unchanged, `turn` unchanged, `move_ready` = 1.
- **Draw:** play the sequence 0, 1, 2, 4, 3, 5, 7, 6, 8. Expect `board_occ` = 9'h1FF, `winner` = 11.
- **O diagonal win:** sequence X 0, O 2, X 1, O 4, X 8, O 6. Expect `winner` = 10, `board_o` = 9'h054.
- **`new_game` during DONE combined with a same-cycle `move_valid`:** expect all outputs at reset values, no ack, no err. Also, `move_valid` held in DONE produces no pulses.
- **`rst` asserted asynchronously while in CHECK:** expect outputs at reset values immediately, without waiting for a clock edge. With `FIRST_PLAYER` = 1, `turn` = 1 after reset.
